// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types: loader states and header size
package pipeline_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        DONE,
        ERROR
    } loader_state_e;

    localparam int LOADER_HDR_BYTES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - little-endian byte-to-word assembler with completion flag
module byte_assembler #(
    parameter int NBYTES = 4,
    parameter int CW     = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                valid_i,
    input  logic [7:0]          data_i,
    input  logic [CW-1:0]       last_idx_i,
    output logic [NBYTES*8-1:0] word_o,
    output logic                complete_o
);

    logic [NBYTES*8-1:0] shreg_q;
    logic [CW-1:0]       cnt_q;

    // word_o already contains the byte being accepted, so a completed word
    // can be registered by the consumer in the same cycle.
    always_comb begin
        word_o = shreg_q;
        for (int k = 0; k < NBYTES; k++) begin
            if (valid_i && cnt_q == CW'(k)) begin
                word_o[8*k +: 8] = data_i;
            end
        end
    end

    assign complete_o = valid_i && (cnt_q == last_idx_i);

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (valid_i) begin
            shreg_q <= word_o;
            cnt_q   <= complete_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - fills imem from a byte stream (32-bit LE count + LE words), holding the core meanwhile
module imem_loader
    import pipeline_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MEMORY_CAPACITY = 256,
    localparam int AW             = $clog2(MEMORY_CAPACITY)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            byte_valid_i,
    input  logic [7:0]      byte_data_i,
    output logic            byte_ready_o,
    output logic            we_o,
    output logic [AW-1:0]   waddr_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            core_hold_o,
    output logic            done_o,
    output logic            error_o,
    output logic [AW:0]     words_loaded_o
);

    localparam int BPW = XLEN / 8;
    localparam int NB  = max_int(BPW, LOADER_HDR_BYTES);
    localparam int CW  = max_int(2, $clog2(BPW));

    loader_state_e   state_q;
    logic [31:0]     n_q;
    logic [AW-1:0]   word_idx_q;
    logic [AW:0]     words_loaded_q;
    logic            we_q;
    logic [AW-1:0]   waddr_q;
    logic [XLEN-1:0] wdata_q;
    logic            done_q;
    logic            error_q;

    logic            xfer;
    logic            start_ok;
    logic [CW-1:0]   last_idx;
    logic [NB*8-1:0] asm_word;
    logic            asm_complete;
    logic [31:0]     hdr_n;
    logic            last_word;

    assign byte_ready_o = (state_q == HEADER) || (state_q == LOAD);
    assign xfer         = byte_valid_i && byte_ready_o;
    assign start_ok     = start_i && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign last_idx     = (state_q == HEADER) ? CW'(LOADER_HDR_BYTES - 1) : CW'(BPW - 1);
    assign hdr_n        = asm_word[31:0];
    assign last_word    = (32'(words_loaded_q) + 32'd1) == n_q;

    // One assembler serves both the header count and the instruction words;
    // only the completing byte index differs between the two phases.
    byte_assembler #(
        .NBYTES (NB),
        .CW     (CW)
    ) u_asm (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (start_ok),
        .valid_i    (xfer),
        .data_i     (byte_data_i),
        .last_idx_i (last_idx),
        .word_o     (asm_word),
        .complete_o (asm_complete)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            n_q            <= '0;
            word_idx_q     <= '0;
            words_loaded_q <= '0;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start_i) begin
                        state_q        <= HEADER;
                        word_idx_q     <= '0;
                        words_loaded_q <= '0;
                        done_q         <= 1'b0;
                        error_q        <= 1'b0;
                    end
                end
                HEADER: begin
                    if (asm_complete) begin
                        n_q <= hdr_n;
                        if (hdr_n == 32'd0 || hdr_n > 32'(MEMORY_CAPACITY)) begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (asm_complete) begin
                        we_q           <= 1'b1;
                        waddr_q        <= word_idx_q;
                        wdata_q        <= asm_word[XLEN-1:0];
                        words_loaded_q <= words_loaded_q + 1'b1;
                        // word_idx stops at the last address so it never wraps at full capacity
                        if (last_word) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            word_idx_q <= word_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we_o           = we_q;
    assign waddr_o        = waddr_q;
    assign wdata_o        = wdata_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_loaded_q;
    assign core_hold_o    = byte_ready_o || we_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        we_o;
    logic [7:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        core_hold_o;
    logic        done_o;
    logic        error_o;
    logic [8:0]  words_loaded_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [39:0] wq[$];

    imem_loader #(
        .XLEN            (32),
        .MEMORY_CAPACITY (256)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .byte_valid_i   (byte_valid_i),
        .byte_data_i    (byte_data_i),
        .byte_ready_o   (byte_ready_o),
        .we_o           (we_o),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o),
        .core_hold_o    (core_hold_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;
    always @(negedge clk_i) if (we_o) wq.push_back({waddr_o, wdata_o});

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit rdy = 1'b0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int t = 0; t < 20 && !rdy; t++) begin
            rdy = byte_ready_o;
            tick();
        end
        byte_valid_i = 1'b0;
        if (!rdy) check_vec("byte_timeout", 64'd0, 64'd1);
        if (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_ready"}, byte_ready_o, 0);
        check_vec({tag, "_we"}, we_o, 0);
        check_vec({tag, "_hold"}, core_hold_o, 0);
        check_vec({tag, "_done"}, done_o, 0);
        check_vec({tag, "_error"}, error_o, 0);
        check_vec({tag, "_waddr"}, waddr_o, 0);
        check_vec({tag, "_wdata"}, wdata_o, 0);
        check_vec({tag, "_loaded"}, words_loaded_o, 0);
    endtask

    task automatic check_nominal_writes(input string tag);
        check_vec({tag, "_nwr"}, wq.size(), 2);
        if (wq.size() == 2) begin
            check_vec({tag, "_wr0"}, wq[0], {8'd0, 32'h0000_0013});
            check_vec({tag, "_wr1"}, wq[1], {8'd1, 32'h0010_0093});
        end
        check_vec({tag, "_done"}, done_o, 1);
        check_vec({tag, "_loaded"}, words_loaded_o, 2);
    endtask

    initial begin
        int c0;
        int bad;
        logic [31:0] iv;
        logic [39:0] expw;

        reset_i      = 1'b1;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        tick();
        tick();
        check_reset_outputs("rst");
        reset_i = 1'b0;
        tick();

        // nominal load; first header byte presented together with start must not be consumed
        wq.delete();
        start_i      = 1'b1;
        byte_valid_i = 1'b1;
        byte_data_i  = 8'h02;
        tick();
        start_i = 1'b0;
        check_vec("nom_hdr_ready", byte_ready_o, 1);
        check_vec("nom_hdr_hold", core_hold_o, 1);
        c0 = cyc;
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        check_vec("nom_cycles", cyc - c0, 12);
        check_vec("nom_last_we", we_o, 1);
        check_vec("nom_last_done", done_o, 1);
        check_vec("nom_last_hold", core_hold_o, 1);
        check_vec("nom_last_waddr", waddr_o, 1);
        check_vec("nom_last_wdata", wdata_o, 32'h0010_0093);
        tick();
        check_vec("nom_hold_fall", core_hold_o, 0);
        check_vec("nom_we_fall", we_o, 0);
        check_vec("nom_done_ready", byte_ready_o, 0);
        byte_valid_i = 1'b1;
        byte_data_i  = 8'hAA;
        tick();
        tick();
        byte_valid_i = 1'b0;
        tick();
        check_nominal_writes("nom");

        // backpressure: valid toggles every cycle
        wq.delete();
        pulse_start();
        send_word(32'd2, 1'b1);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_0093, 1'b1);
        tick();
        check_nominal_writes("bp");

        // start during LOAD is ignored
        wq.delete();
        pulse_start();
        send_word(32'd2, 1'b0);
        send_byte(8'h13, 1'b0);
        start_i = 1'b1;
        send_byte(8'h00, 1'b0);
        start_i = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        tick();
        check_nominal_writes("ign");

        // header reject N=0
        wq.delete();
        pulse_start();
        send_word(32'd0, 1'b0);
        check_vec("n0_error", error_o, 1);
        check_vec("n0_ready", byte_ready_o, 0);
        check_vec("n0_done", done_o, 0);
        tick();
        tick();
        check_vec("n0_nwr", wq.size(), 0);

        // header reject N=capacity+1
        pulse_start();
        check_vec("n257_clr_error", error_o, 0);
        send_word(32'h0000_0101, 1'b0);
        check_vec("n257_error", error_o, 1);
        check_vec("n257_ready", byte_ready_o, 0);
        check_vec("n257_hold", core_hold_o, 0);
        tick();
        tick();
        check_vec("n257_nwr", wq.size(), 0);

        // full capacity, word i = i
        wq.delete();
        pulse_start();
        send_word(32'd256, 1'b0);
        for (int i = 0; i < 256; i++) send_word(32'(i), 1'b0);
        check_vec("full_we", we_o, 1);
        check_vec("full_waddr", waddr_o, 8'd255);
        check_vec("full_wdata", wdata_o, 32'd255);
        check_vec("full_done", done_o, 1);
        tick();
        check_vec("full_loaded", words_loaded_o, 9'd256);
        check_vec("full_nwr", wq.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < wq.size(); i++) begin
            iv   = 32'(i);
            expw = {iv[7:0], iv};
            if (wq[i] !== expw) bad++;
        end
        check_vec("full_seq", bad, 0);

        // reset after 6 LOAD bytes, then a clean reload
        wq.delete();
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b0);
        reset_i = 1'b1;
        tick();
        check_reset_outputs("midrst");
        reset_i = 1'b0;
        tick();
        wq.delete();
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        tick();
        check_nominal_writes("reload");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
